// File: rtl/alu_pkg.sv
// Shared definitions for the ALU front end and its bench.
// Contents: opcode encodings, arbiter FSM state type, and alu_op_legal(),
// which reports whether a 4-bit opcode is one the ALU defines.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0011;
    localparam logic [3:0] OP_DIV  = 4'b0111;
    localparam logic [3:0] OP_AND  = 4'b1111;
    localparam logic [3:0] OP_OR   = 4'b1000;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_NAND = 4'b1011;
    localparam logic [3:0] OP_NOR  = 4'b1010;
    localparam logic [3:0] OP_XOR  = 4'b1100;
    localparam logic [3:0] OP_XNOR = 4'b1101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESP
    } state_t;

    function automatic logic alu_op_legal(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR,
            OP_NOT, OP_NAND, OP_NOR, OP_XOR, OP_XNOR: return 1'b1;
            default:                                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational 4-bit ALU datapath (shared by all requesters via alu_arbiter).
// Ports: a, b (4-bit operands), op (4-bit opcode), r (8-bit result).
// Operands are zero-extended to 8 bits; undefined opcodes and divide by
// zero yield 0 here (the arbiter decides error reporting).
module alu
    import alu_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] op,
    output logic [7:0] r
);

    logic [7:0] a8;
    logic [7:0] b8;

    assign a8 = {4'b0000, a};
    assign b8 = {4'b0000, b};

    always_comb begin
        r = '0;
        case (op)
            OP_ADD:  r = a8 + b8;
            OP_SUB:  r = a8 - b8;
            OP_MUL:  r = a8 * b8;
            OP_DIV:  r = (b8 == 8'h00) ? 8'h00 : a8 / b8;
            OP_AND:  r = a8 & b8;
            OP_OR:   r = a8 | b8;
            // Inverting ops act on the zero-extended value, so the upper nibble becomes 1s.
            OP_NOT:  r = ~a8;
            OP_NAND: r = ~(a8 & b8);
            OP_NOR:  r = ~(a8 | b8);
            OP_XOR:  r = a8 ^ b8;
            OP_XNOR: r = ~(a8 ^ b8);
            default: r = '0;
        endcase
    end

endmodule

// File: rtl/alu_rr_pick.sv
// Two-way round-robin picker.
// Ports: valid[1:0] requests, ptr (index holding priority on a tie),
// grant_en (allow a grant this cycle), grant[1:0] one-hot grant,
// ptr_nxt (pointer value to load when a grant is taken).
module alu_rr_pick (
    input  logic [1:0] valid,
    input  logic       ptr,
    input  logic       grant_en,
    output logic [1:0] grant,
    output logic       ptr_nxt
);

    always_comb begin
        grant = '0;
        if (grant_en) begin
            if (valid == 2'b11) begin
                grant = ptr ? 2'b10 : 2'b01;
            end else begin
                grant = valid;
            end
        end
        // Priority passes to the requester that was not just granted.
        ptr_nxt = ptr;
        if (grant[0]) begin
            ptr_nxt = 1'b1;
        end else if (grant[1]) begin
            ptr_nxt = 1'b0;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end for the shared ALU: round-robin grant, one
// operation in flight, registered operands and response.
// Ports: clk, rst_n (async active-low); reqN_valid/reqN_ready handshake with
// reqN_A, reqN_B, reqN_OP; response rsp_valid/rsp_ready with rsp_id
// (issuing requester), rsp_R (8-bit result) and rsp_err (bad opcode or /0).
module alu_arbiter
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [3:0] req0_A,
    input  logic [3:0] req0_B,
    input  logic [3:0] req0_OP,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [3:0] req1_A,
    input  logic [3:0] req1_B,
    input  logic [3:0] req1_OP,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [7:0] rsp_R,
    output logic       rsp_err
);

    state_t     state;
    state_t     state_nxt;
    logic       ptr;
    logic       ptr_nxt;
    logic       grant_en;
    logic [1:0] grant;
    logic [3:0] a_q;
    logic [3:0] b_q;
    logic [3:0] op_q;
    logic       id_q;
    logic [7:0] r_q;
    logic       err_q;
    logic [7:0] alu_r;
    logic [7:0] res_nxt;
    logic       err_nxt;

    assign grant_en = (state == ST_IDLE);

    alu_rr_pick u_pick (
        .valid    ({req1_valid, req0_valid}),
        .ptr      (ptr),
        .grant_en (grant_en),
        .grant    (grant),
        .ptr_nxt  (ptr_nxt)
    );

    alu u_alu (
        .a  (a_q),
        .b  (b_q),
        .op (op_q),
        .r  (alu_r)
    );

    // Error cases override the ALU output entirely.
    always_comb begin
        res_nxt = alu_r;
        err_nxt = 1'b0;
        if (!alu_op_legal(op_q)) begin
            res_nxt = 8'h00;
            err_nxt = 1'b1;
        end else if (op_q == OP_DIV && b_q == 4'h0) begin
            res_nxt = 8'hFF;
            err_nxt = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (|grant)    state_nxt = ST_EXEC;
            ST_EXEC:                state_nxt = ST_RESP;
            ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
            default:                state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            ptr   <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            id_q  <= 1'b0;
            r_q   <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (|grant) begin
                ptr  <= ptr_nxt;
                a_q  <= grant[1] ? req1_A  : req0_A;
                b_q  <= grant[1] ? req1_B  : req0_B;
                op_q <= grant[1] ? req1_OP : req0_OP;
                id_q <= grant[1];
            end
            if (state == ST_EXEC) begin
                r_q   <= res_nxt;
                err_q <= err_nxt;
            end
        end
    end

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign rsp_valid  = (state == ST_RESP);
    assign rsp_id     = id_q;
    assign rsp_R      = r_q;
    assign rsp_err    = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: stimulus pushes expected grants and
// responses; independent monitors pop and compare when the DUT presents them.
module tb_alu_arbiter;
    import alu_pkg::*;

    typedef struct packed {
        logic       id;
        logic [7:0] r;
        logic       err;
    } rsp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_ready, req1_ready;
    logic [3:0] req0_A = '0, req0_B = '0, req0_OP = '0;
    logic [3:0] req1_A = '0, req1_B = '0, req1_OP = '0;
    logic       rsp_valid, rsp_id, rsp_err;
    logic       rsp_ready = 1'b1;
    logic [7:0] rsp_R;

    alu_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_A     (req0_A),
        .req0_B     (req0_B),
        .req0_OP    (req0_OP),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_A     (req1_A),
        .req1_B     (req1_B),
        .req1_OP    (req1_OP),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_R      (rsp_R),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   tests = 0;
    int   fails = 0;
    int unsigned grants_seen = 0;
    int unsigned grant_cyc = 0;
    logic prev_valid = 1'b0;
    rsp_t exp_q[$];
    logic exp_g[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Grant monitor and per-cycle handshake rules.
    always @(negedge clk) begin
        if (rst_n) begin
            check("ready_onehot", 32'(req0_ready & req1_ready), 0);
            check("ready_needs_valid", 32'((req0_ready & ~req0_valid) | (req1_ready & ~req1_valid)), 0);
            if (rsp_valid) check("ready_in_resp", 32'(req0_ready | req1_ready), 0);
            if (req0_ready | req1_ready) begin
                grants_seen++;
                grant_cyc = cyc;
                if (exp_g.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL grant_unexpected: got id %0d expected none", req1_ready);
                end else begin
                    check("grant_id", 32'(req1_ready), 32'(exp_g.pop_front()));
                end
            end
        end
    end

    // Response monitor.
    always @(negedge clk) begin
        rsp_t e;
        if (rsp_valid && !prev_valid) check("latency", cyc - grant_cyc, 2);
        if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rsp_unexpected: got id %0d R %0h expected none", rsp_id, rsp_R);
            end else begin
                e = exp_q.pop_front();
                check("rsp_id", 32'(rsp_id), 32'(e.id));
                check("rsp_R", 32'(rsp_R), 32'(e.r));
                check("rsp_err", 32'(rsp_err), 32'(e.err));
            end
        end
        prev_valid = rsp_valid;
    end

    task automatic drive(input logic id, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] op, input logic v);
        if (id) begin
            req1_A = a; req1_B = b; req1_OP = op; req1_valid = v;
        end else begin
            req0_A = a; req0_B = b; req0_OP = op; req0_valid = v;
        end
    endtask

    task automatic wait_grants(input int unsigned target, input int budget);
        int n;
        n = 0;
        while (grants_seen < target && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        tests++;
        if (grants_seen < target) begin
            fails++;
            $display("FAIL grant_timeout: got %0d grants expected %0d", grants_seen, target);
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_pending", exp_q.size(), 0);
    endtask

    task automatic issue(input logic id, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] op, input logic [7:0] er, input logic ee);
        int unsigned target;
        target = grants_seen + 1;
        exp_q.push_back('{id, er, ee});
        exp_g.push_back(id);
        drive(id, a, b, op, 1'b1);
        wait_grants(target, 20);
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    function automatic logic [8:0] model(input int a, input int b, input logic [3:0] op);
        int r;
        logic e;
        e = 1'b0;
        r = 0;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = (a - b) & 255;
            OP_MUL:  r = a * b;
            OP_DIV:  if (b == 0) begin r = 255; e = 1'b1; end else r = a / b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_NOT:  r = 240 + (15 - a);
            OP_NAND: r = 240 + (15 - (a & b));
            OP_NOR:  r = 240 + (15 - (a | b));
            OP_XOR:  r = a ^ b;
            OP_XNOR: r = 240 + (15 - (a ^ b));
            default: begin r = 0; e = 1'b1; end
        endcase
        return {e, r[7:0]};
    endfunction

    initial begin
        logic [15:0] legal_mask;
        logic [3:0]  ops [11];
        logic [8:0]  m;
        int unsigned target;
        int          n;

        // Reset values.
        repeat (2) @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_id", 32'(rsp_id), 0);
        check("rst_rsp_R", 32'(rsp_R), 0);
        check("rst_rsp_err", 32'(rsp_err), 0);
        check("rst_ready", 32'({req1_ready, req0_ready}), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        legal_mask = 16'hBF8B;
        for (int i = 0; i < 16; i++) check("op_legal", 32'(alu_op_legal(4'(i))), 32'(legal_mask[i]));

        // Single request, errors.
        issue(1'b0, 4'h9, 4'h7, OP_ADD, 8'h10, 1'b0);
        issue(1'b1, 4'h8, 4'h0, OP_DIV, 8'hFF, 1'b1);
        issue(1'b0, 4'h5, 4'h5, 4'h2,   8'h00, 1'b1);
        drain(20);

        // Backpressure on NOT 3 with req0 waiting.
        rsp_ready = 1'b0;
        target = grants_seen + 1;
        exp_g.push_back(1'b1);
        exp_g.push_back(1'b0);
        exp_q.push_back('{1'b1, 8'hFC, 1'b0});
        exp_q.push_back('{1'b0, 8'h02, 1'b0});
        drive(1'b1, 4'h3, 4'h5, OP_NOT, 1'b1);
        wait_grants(target, 20);
        req1_valid = 1'b0;
        drive(1'b0, 4'h1, 4'h1, OP_ADD, 1'b1);
        n = 0;
        while (!rsp_valid && n < 10) begin @(posedge clk); #1; n++; end
        check("bp_rsp_seen", 32'(rsp_valid), 1);
        repeat (5) begin
            @(negedge clk);
            check("bp_valid", 32'(rsp_valid), 1);
            check("bp_R", 32'(rsp_R), 32'h FC);
            check("bp_id", 32'(rsp_id), 1);
            check("bp_err", 32'(rsp_err), 0);
            check("bp_req0_ready", 32'(req0_ready), 0);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_accepted", 32'(rsp_valid), 0);
        wait_grants(target + 1, 20);
        req0_valid = 1'b0;
        drain(20);

        // Reset while in EXEC: transaction dropped, outputs cleared at once.
        target = grants_seen + 1;
        exp_g.push_back(1'b1);
        drive(1'b1, 4'h2, 4'h2, OP_ADD, 1'b1);
        wait_grants(target, 20);
        req1_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(rsp_valid), 0);
        check("mid_rst_R", 32'(rsp_R), 0);
        check("mid_rst_id", 32'(rsp_id), 0);
        check("mid_rst_err", 32'(rsp_err), 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("post_rst_no_rsp", 32'(rsp_valid), 0);
        end
        @(posedge clk); #1;

        // Contention straight after reset: req0 first, then alternate.
        target = grants_seen + 4;
        for (int i = 0; i < 2; i++) begin
            exp_g.push_back(1'b0);
            exp_g.push_back(1'b1);
            exp_q.push_back('{1'b0, 8'hE1, 1'b0});
            exp_q.push_back('{1'b1, 8'hFE, 1'b0});
        end
        drive(1'b0, 4'hF, 4'hF, OP_MUL, 1'b1);
        drive(1'b1, 4'h3, 4'h5, OP_SUB, 1'b1);
        wait_grants(target, 40);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain(20);

        // Sweep of all legal opcodes and operand pairs.
        ops = '{OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR,
                OP_NOT, OP_NAND, OP_NOR, OP_XOR, OP_XNOR};
        for (int o = 0; o < 11; o++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    m = model(a, b, ops[o]);
                    issue(a[0], a[3:0], b[3:0], ops[o], m[7:0], m[8]);
                end
            end
        end
        drain(50);
        check("grants_pending", exp_g.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
